simt_core: RTL and testbench
============================

# simt_core

Multi-thread successor to the single-thread GPU datapath. It executes one instruction stream in lock-step across `N_THREADS` lanes, and each lane has its own register file and ALU. A multi-cycle FSM fetches from an external instruction memory. Loads and stores from all lanes are serialised through one req/ack data-memory port. A `start`/`done` handshake launches a kernel from a given PC and reports when it hits `HALT`.

## Interface
Parameters:
- `N_THREADS`, 4: number of lanes (≥1); lane index doubles as thread_idx.
- `DATA_W`, 16: register/ALU/data width.
- `ADDR_W`, 16: data-memory address width.
- `PC_W`, 16: instruction address width.

Ports:
- `clk` input 1: single clock. All state is updated on the rising edge.
- `reset` input 1: synchronous, active-low.
- `start` input 1: launch request. Sampled only in IDLE.
- `start_pc` input PC_W: first instruction address, captured with `start`.
- `block_idx` input DATA_W: value read through r13.
- `block_dim` input DATA_W: value read through r14.
- `busy` output 1: high from the cycle after start is accepted until DONE.
- `done` output 1: one-cycle pulse when HALT retires.
- `imem_addr` output PC_W: instruction fetch address.
- `imem_rdata` input 32: instruction. Valid the cycle after `imem_addr` is presented, so read latency is 1.
- `mem_req` output 1: data access request.
- `mem_we` output 1: 1 means store, 0 means load.
- `mem_addr` output ADDR_W: data address.
- `mem_wdata` output DATA_W: store data.
- `mem_rdata` input DATA_W: load data. Valid in the `mem_ack` cycle.
- `mem_ack` input 1: access complete.

## Operation
- Instruction fields:
  - [15:12] opcode
  - [11:8] rd
  - [7:4] rs2
  - [3:0] rs1
  - [31:16] imm, sign-extended to DATA_W
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL (low DATA_W bits), 3 AND, 4 OR, 5 XOR: rd = rs1 op rs2.
  - 6 LW: rd = M[rs1+imm].
  - 7 SW: M[rs1+imm] = rs2.
  - 8 ADDI: rd = rs1+imm.
  - 9 JMP: pc = imm[PC_W-1:0].
  - 15 HALT.
  - 10–14: NOP.
- Arithmetic: wraps modulo 2^DATA_W. Memory address is the low ADDR_W bits of rs1+imm.
- Registers r0–r12 are general purpose.
- Special registers:
  - r13 reads `block_idx`.
  - r14 reads `block_dim`.
  - r15 reads the lane number, zero-extended.
  - Writes to r13–r15 are discarded.
- FSM states and transitions:
  - IDLE: on `start`, set pc = start_pc and go to FETCH.
  - FETCH: drive imem_addr = pc, go to DECODE.
  - DECODE: latch imem_rdata into the instruction register, go to EXEC.
  - EXEC, by instruction:
    - ALU/ADDI: all lanes write rd, pc+1, go to FETCH.
    - JMP: load pc, go to FETCH.
    - NOP: pc+1, go to FETCH.
    - LW/SW: lane counter = 0, go to MEM.
    - HALT: go to DONE.
  - MEM: drive the current lane's access; on `mem_ack`, handle the lane as below.
  - DONE: `done`=1 for this single cycle, then go to IDLE.
- MEM lane handling on `mem_ack`:
  - For LW, write mem_rdata into that lane's rd in the same edge.
  - If this is the last lane, pc+1 and go to FETCH; otherwise increment the lane counter.
- `imem_addr` = pc in every state.

## Timing
- Reset values: state IDLE, pc 0, all registers 0, busy/done/mem_req/mem_we 0, mem_addr/mem_wdata 0, instruction register 0.
- Instruction latency:
  - ALU/ADDI/JMP/NOP take 3 cycles (FETCH, DECODE, EXEC). The register write is visible to the next instruction's EXEC.
  - LW/SW take 3 + Σ(lane wait) cycles, where each lane needs ≥1 cycle and ends with its ack.
- mem_req handshake:
  - `mem_req` is high for the whole MEM state.
  - addr/we/wdata are stable until ack.
  - The next lane's values appear the cycle after ack, with req still high.
  - `mem_req` drops the cycle after the last lane's ack.
- `mem_ack` while `mem_req`=0 is ignored.
- `start` while busy is ignored. `start` in the DONE cycle is ignored; it is accepted only from IDLE.
- `busy` timing: high in FETCH/DECODE/EXEC/MEM, low in IDLE and DONE.
- `reset` low in any state: all outputs return to reset values at that edge, including mid-MEM with an outstanding req. No lane write from a same-cycle ack.
- N_THREADS=1: MEM is one lane and the counter width is clamped to 1 bit.

## Structure
- `gpu_pkg` holds:
  - the opcode enum;
  - the FSM state enum;
  - NUM_REGS=16;
  - special register indices (REG_BIDX=13, REG_BDIM=14, REG_TIDX=15);
  - instruction field position constants.
- `simt_lane` sub-module, one instance per lane via generate:
  - 16×DATA_W register file with special-register read mux and write suppression;
  - ALU;
  - address adder.
- simt_core holds the FSM, pc, instruction register, lane counter, and the memory-port mux over lanes.

## Test plan
- Reset with `reset`=0 for 2 cycles -> busy=0, done=0, mem_req=0, imem_addr=0; after release, no activity without start.
- N_THREADS=4, block_idx=2, block_dim=4, program "ADD r1,r15,r0 ; MUL r2,r13,r14 ; ADD r3,r2,r1 ; SW r3→[r1+0x10] ; HALT" -> four stores in lane order with addresses 0x10..0x13 and data 8,9,10,11; done pulses once.
- Memory stalls: SW per previous test with ack delays of 0,3,1,2 cycles -> mem_addr/mem_wdata stable while waiting, no lane skipped or repeated, req drops the cycle after the 4th ack.
- LW with mem_rdata = 0x100+lane, then `ADDI r5,r4,1` -> lane k r5 = 0x101+k; `ADD r15,r0,r0` followed by reading r15 still returns the lane number.
- JMP/NOP/protocol: JMP to 0x20, NOP at 0x20, HALT at 0x21 -> fetch addresses start_pc, 0x20, 0x21; start pulsed mid-run ignored; done is 1 cycle and the next start is accepted from IDLE.
- Reset asserted during lane 2's pending LW -> mem_req=0 at that edge, lane 2 rd unchanged (0), state IDLE.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared encodings for the SIMT core: opcodes, FSM states, register map
// and instruction field positions.
package gpu_pkg;
    localparam int NUM_REGS = 16;
    localparam int FIELD_W  = 4;

    localparam logic [FIELD_W-1:0] REG_BIDX = 4'd13;
    localparam logic [FIELD_W-1:0] REG_BDIM = 4'd14;
    localparam logic [FIELD_W-1:0] REG_TIDX = 4'd15;

    localparam int RS1_LSB = 0;
    localparam int RS2_LSB = 4;
    localparam int RD_LSB  = 8;
    localparam int OPC_LSB = 12;
    localparam int IMM_LSB = 16;
    localparam int IMM_W   = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_ADDI = 4'd8,
        OP_JMP  = 4'd9,
        OP_HALT = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_DONE
    } state_e;

    function automatic logic writes_rd(input logic [3:0] op);
        return (op <= OP_XOR) || (op == OP_ADDI);
    endfunction
endpackage

// File: rtl/simt_lane.sv
// One SIMT lane: register file with special-register reads, ALU and
// load/store address adder.
module simt_lane
    import gpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LANE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        op,
    input  logic [3:0]        rd,
    input  logic [3:0]        rs1,
    input  logic [3:0]        rs2,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] block_idx,
    input  logic [DATA_W-1:0] block_dim,
    input  logic              alu_we,
    input  logic              ld_we,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] store_data
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] a, b, alu_res, sum;

    always_comb begin
        case (rs1)
            REG_BIDX: a = block_idx;
            REG_BDIM: a = block_dim;
            REG_TIDX: a = DATA_W'(LANE);
            default:  a = regs[rs1];
        endcase
        case (rs2)
            REG_BIDX: b = block_idx;
            REG_BDIM: b = block_dim;
            REG_TIDX: b = DATA_W'(LANE);
            default:  b = regs[rs2];
        endcase
    end

    always_comb begin
        sum = a + imm;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_MUL:  alu_res = a * b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ADDI: alu_res = sum;
            default: alu_res = '0;
        endcase
    end

    assign addr       = ADDR_W'(sum);
    assign store_data = b;

    // r13..r15 are read-only views; writes to them are dropped here
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (rd < REG_BIDX) begin
            if (ld_we)       regs[rd] <= ld_data;
            else if (alu_we) regs[rd] <= alu_res;
        end
    end
endmodule

// File: rtl/simt_core.sv
// Lock-step SIMT core: multi-cycle fetch/decode/exec FSM driving N_THREADS
// lanes, with loads/stores serialised lane by lane over one req/ack port.
module simt_core
    import gpu_pkg::*;
#(
    parameter int N_THREADS = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int PC_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    input  logic [DATA_W-1:0] block_idx,
    input  logic [DATA_W-1:0] block_dim,
    output logic              busy,
    output logic              done,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int LCW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

    state_e            state, state_nxt;
    logic [PC_W-1:0]   pc;
    logic [31:0]       ir;
    logic [LCW-1:0]    lane_cnt;
    logic [3:0]        op, rd, rs1, rs2;
    logic [DATA_W-1:0] imm;
    logic              last_lane, alu_we;

    logic [N_THREADS-1:0][ADDR_W-1:0] lane_addr;
    logic [N_THREADS-1:0][DATA_W-1:0] lane_sdata;

    assign op        = ir[OPC_LSB +: FIELD_W];
    assign rd        = ir[RD_LSB  +: FIELD_W];
    assign rs2       = ir[RS2_LSB +: FIELD_W];
    assign rs1       = ir[RS1_LSB +: FIELD_W];
    assign imm       = DATA_W'($signed(ir[IMM_LSB +: IMM_W]));
    assign last_lane = (lane_cnt == LCW'(N_THREADS - 1));
    assign alu_we    = (state == ST_EXEC) && writes_rd(op);

    for (genvar g = 0; g < N_THREADS; g++) begin : g_lane
        logic ld_we;
        assign ld_we = (state == ST_MEM) && mem_ack && (op == OP_LW) &&
                       (lane_cnt == LCW'(g));
        simt_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANE(g)) u_lane (
            .clk        (clk),
            .reset      (reset),
            .op         (op),
            .rd         (rd),
            .rs1        (rs1),
            .rs2        (rs2),
            .imm        (imm),
            .block_idx  (block_idx),
            .block_dim  (block_dim),
            .alu_we     (alu_we),
            .ld_we      (ld_we),
            .ld_data    (mem_rdata),
            .addr       (lane_addr[g]),
            .store_data (lane_sdata[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = ST_MEM;
                    OP_HALT:      state_nxt = ST_DONE;
                    default:      state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM:    if (mem_ack && last_lane) state_nxt = ST_FETCH;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode straight from state, so a reset edge clears them at once
    always_comb begin
        busy      = (state == ST_FETCH) || (state == ST_DECODE) ||
                    (state == ST_EXEC)  || (state == ST_MEM);
        done      = (state == ST_DONE);
        imem_addr = pc;
        mem_req   = (state == ST_MEM);
        mem_we    = (state == ST_MEM) && (op == OP_SW);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ST_MEM) begin
            for (int i = 0; i < N_THREADS; i++) begin
                if (lane_cnt == LCW'(i)) begin
                    mem_addr  = lane_addr[i];
                    mem_wdata = lane_sdata[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc       <= '0;
            ir       <= '0;
            lane_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE:   if (start) pc <= start_pc;
                ST_DECODE: ir <= imem_rdata;
                ST_EXEC: begin
                    case (op)
                        OP_JMP:       pc <= PC_W'(ir[IMM_LSB +: IMM_W]);
                        OP_LW, OP_SW: lane_cnt <= '0;
                        OP_HALT:      ;
                        default:      pc <= pc + PC_W'(1);
                    endcase
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (last_lane) pc <= pc + PC_W'(1);
                        else           lane_cnt <= lane_cnt + LCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_simt_core.sv
// Scoreboard bench for simt_core: expected memory accesses are queued per
// program and checked by the data-memory responder as each lane is acked.
module tb_simt_core;
    localparam int N = 4;

    logic        clk = 0, reset = 0, start = 0;
    logic [15:0] start_pc = 0, block_idx = 16'd2, block_dim = 16'd4;
    logic        busy, done, mem_req, mem_we, mem_ack = 0;
    logic [15:0] imem_addr, mem_addr, mem_wdata, mem_rdata = 0;
    logic [31:0] imem_rdata = 0;
    logic [31:0] imem [0:255];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    acc_t        sb[$];
    int          delays[$];
    logic [15:0] trace[$];
    int          errors = 0, checks = 0;

    simt_core #(.N_THREADS(N), .DATA_W(16), .ADDR_W(16), .PC_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .block_idx(block_idx), .block_dim(block_dim), .busy(busy), .done(done),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem[imem_addr[7:0]];

    function automatic logic [31:0] enc(input int op, input int rd, input int rs2,
                                        input int rs1, input int imm);
        logic [15:0] i16;
        i16 = 16'(imm);
        return {i16, 4'(op), 4'(rd), 4'(rs2), 4'(rs1)};
    endfunction

    function automatic acc_t acc(input logic we, input int addr, input int data);
        acc_t a;
        a.we = we; a.addr = 16'(addr); a.data = 16'(data);
        return a;
    endfunction

    // Data-memory responder: acks each lane after its queued delay
    logic        in_x = 0, chk_drop = 0, hold_we;
    logic [15:0] hold_addr, hold_data;
    int          tgt, wcnt, ack_cnt = 0;
    acc_t        e;
    always @(negedge clk) begin
        mem_ack = 0;
        if (!reset) begin
            in_x = 0; ack_cnt = 0; chk_drop = 0;
        end else begin
            if (chk_drop) begin
                chk_drop = 0;
                checks++;
                if (mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL req_drop: mem_req=%b required 0 after last lane ack", mem_req);
                end
            end
            if (!mem_req) begin
                in_x = 0;
            end else begin
                if (!in_x) begin
                    in_x = 1; wcnt = 0;
                    tgt = (delays.size() != 0) ? delays.pop_front() : 0;
                    hold_we = mem_we; hold_addr = mem_addr; hold_data = mem_wdata;
                end else begin
                    checks++;
                    if (mem_we !== hold_we || mem_addr !== hold_addr || mem_wdata !== hold_data) begin
                        errors++;
                        $display("FAIL stable: we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, hold_we, hold_addr, hold_data);
                    end
                end
                if (wcnt == tgt) begin
                    mem_rdata = 16'h100 + 16'(ack_cnt % N);
                    mem_ack = 1; in_x = 0;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL access: unexpected we=%b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
                    end else begin
                        e = sb.pop_front();
                        if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
                            errors++;
                            $display("FAIL access: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                                     mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
                        end
                    end
                    ack_cnt++;
                    if (ack_cnt % N == 0) chk_drop = 1;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Returns at the negedge where done is seen (or the budget runs out)
    task automatic wait_done(input int limit, input int poke, output int cyc);
        cyc = 0;
        trace.delete();
        while (cyc < limit) begin
            @(negedge clk);
            start = 0;
            cyc++;
            if (busy && (trace.size() == 0 || trace[$] != imem_addr)) trace.push_back(imem_addr);
            if (done) break;
            if (cyc == poke) begin
                start_pc = 16'h0000;
                start = 1;
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_seen: done=%b busy=%b after %0d cycles, required done=1 busy=0", done, busy, cyc);
        end
    endtask

    task automatic run_kernel(input logic [15:0] pc, input int limit, input int poke, output int cyc);
        start_pc = pc;
        @(negedge clk);
        start = 1;
        wait_done(limit, poke, cyc);
    endtask

    task automatic after_done();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b one cycle after done, required 0 0", done, busy);
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d expected accesses left, required 0", name, sb.size());
        end
    endtask

    task automatic load_store_prog();
        imem[0] = enc(0, 1, 0, 15, 0);     // ADD r1,r15,r0
        imem[1] = enc(2, 2, 14, 13, 0);    // MUL r2,r13,r14
        imem[2] = enc(0, 3, 1, 2, 0);      // ADD r3,r2,r1
        imem[3] = enc(7, 0, 3, 1, 'h10);   // SW r3 -> [r1+0x10]
        imem[4] = enc(15, 0, 0, 0, 0);
        for (int k = 0; k < N; k++) sb.push_back(acc(1'b1, 'h10 + k, 8 + k));
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, mem_req, mem_we} !== 4'b0 || imem_addr !== 16'h0 ||
            mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b req=%b we=%b iaddr=%h addr=%h wdata=%h required all 0",
                     busy, done, mem_req, mem_we, imem_addr, mem_addr, mem_wdata);
        end
        reset = 1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || imem_addr !== 16'h0) begin
            errors++;
            $display("FAIL idle_quiet: busy=%b req=%b iaddr=%h required 0 0 0", busy, mem_req, imem_addr);
        end
    endtask

    task automatic test_store();
        int cyc;
        load_store_prog();
        run_kernel(16'h0000, 200, -1, cyc);
        checks++;
        if (cyc != 20) begin
            errors++;
            $display("FAIL store_latency: %0d cycles, required 20", cyc);
        end
        after_done();
        check_sb_empty("store");
    endtask

    task automatic test_stalls();
        int cyc;
        load_store_prog();
        delays = '{0, 3, 1, 2};
        run_kernel(16'h0000, 200, -1, cyc);
        checks++;
        if (cyc != 26) begin
            errors++;
            $display("FAIL stall_latency: %0d cycles, required 26", cyc);
        end
        after_done();
        check_sb_empty("stall");
    endtask

    task automatic test_load();
        int cyc;
        imem[8]  = enc(6, 4, 0, 0, 'h40);  // LW r4,[r0+0x40]
        imem[9]  = enc(8, 5, 0, 4, 1);     // ADDI r5,r4,1
        imem[10] = enc(7, 0, 5, 15, 'h50); // SW r5 -> [r15+0x50]
        imem[11] = enc(8, 6, 0, 5, -1);    // ADDI r6,r5,-1
        imem[12] = enc(7, 0, 6, 15, -1);   // SW r6 -> [r15-1]
        imem[13] = enc(0, 15, 0, 0, 0);    // ADD r15,r0,r0 (discarded)
        imem[14] = enc(7, 0, 15, 0, 'h60); // SW r15 -> [r0+0x60]
        imem[15] = enc(15, 0, 0, 0, 0);
        for (int k = 0; k < N; k++) sb.push_back(acc(1'b0, 'h40, 0));
        for (int k = 0; k < N; k++) sb.push_back(acc(1'b1, 'h50 + k, 'h101 + k));
        for (int k = 0; k < N; k++) sb.push_back(acc(1'b1, (k + 'hFFFF) & 'hFFFF, 'h100 + k));
        for (int k = 0; k < N; k++) sb.push_back(acc(1'b1, 'h60, k));
        run_kernel(16'h0008, 300, -1, cyc);
        after_done();
        check_sb_empty("load");
    endtask

    task automatic test_jmp_protocol();
        int cyc;
        imem[8'h30] = enc(9, 0, 0, 0, 'h20);
        imem[8'h20] = enc(10, 0, 0, 0, 0);
        imem[8'h21] = enc(15, 0, 0, 0, 0);
        run_kernel(16'h0030, 100, 2, cyc);
        checks++;
        if (trace.size() != 3 || trace[0] != 16'h30 || trace[1] != 16'h20 || trace[2] != 16'h21) begin
            errors++;
            $display("FAIL fetch_trace: %0d addrs first=%h, required 3 addrs 30,20,21",
                     trace.size(), (trace.size() != 0) ? trace[0] : 16'hxxxx);
        end
        start_pc = 16'h0030;
        start = 1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%b done=%b, required 0 0", busy, done);
        end
        @(negedge clk);
        start = 0;
        checks++;
        if (busy !== 1'b1 || imem_addr !== 16'h0030) begin
            errors++;
            $display("FAIL start_from_idle: busy=%b iaddr=%h, required 1 0030", busy, imem_addr);
        end
        wait_done(100, -1, cyc);
        after_done();
    endtask

    task automatic test_reset_mid_mem();
        int cyc;
        bit seen = 0;
        imem[8'h40] = enc(6, 4, 0, 15, 'h90); // LW r4,[r15+0x90]
        imem[8'h41] = enc(15, 0, 0, 0, 0);
        sb.push_back(acc(1'b0, 'h90, 0));
        sb.push_back(acc(1'b0, 'h91, 0));
        delays = '{0, 0, 1000};
        start_pc = 16'h0040;
        @(negedge clk);
        start = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 0;
            if (mem_req && mem_addr == 16'h0092) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL lane2_pending: lane 2 access at 0092 never presented");
        end
        repeat (2) @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || imem_addr !== 16'h0 || mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_mem: req=%b busy=%b done=%b iaddr=%h addr=%h required all 0",
                     mem_req, busy, done, imem_addr, mem_addr);
        end
        in_x = 0; ack_cnt = 0; chk_drop = 0;
        sb.delete(); delays.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        imem[8'h48] = enc(7, 0, 4, 15, 'hA0); // SW r4 -> [r15+0xA0]
        imem[8'h49] = enc(15, 0, 0, 0, 0);
        for (int k = 0; k < N; k++) sb.push_back(acc(1'b1, 'hA0 + k, 0));
        run_kernel(16'h0048, 100, -1, cyc);
        after_done();
        check_sb_empty("post_reset");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_F000;
        test_reset();
        test_store();
        test_stalls();
        test_load();
        test_jmp_protocol();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
